// File: rtl/intra_pkg.sv
// Shared definitions for the 4x4 intra-prediction scheduler.
// Contents: FSM state encodings, mode count and mode encodings, and
// frame-geometry helper functions (blocks per row / per frame).
package intra_pkg;

    localparam int unsigned NUM_MODES = 8;

    // FSM state encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_SAVE    = 3'd3;
    localparam state_t ST_ADVANCE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Intra 4x4 mode encodings; bit position in the done mask
    typedef enum logic [2:0] {
        MODE_V   = 3'd0,
        MODE_H   = 3'd1,
        MODE_DDL = 3'd2,
        MODE_DDR = 3'd3,
        MODE_HU  = 3'd4,
        MODE_HD  = 3'd5,
        MODE_VL  = 3'd6,
        MODE_VR  = 3'd7
    } mode_t;

    function automatic int unsigned blocks_per_row(input int unsigned width);
        return width / 4;
    endfunction

    function automatic int unsigned blocks_per_frame(input int unsigned length,
                                                     input int unsigned width);
        return (length / 4) * (width / 4);
    endfunction

endpackage

// File: rtl/intra_block_counter.sv
// Raster-order 4x4 block counter.
// Ports: clk, reset (sync, active-high), clear (return to block 0),
//        inc (step to next block; held at the last block),
//        mbnumber (block index), blk_row / blk_col (pixel coordinates),
//        last (current block is the final one of the frame).
module intra_block_counter #(
    parameter int unsigned LENGTH = 256,
    parameter int unsigned WIDTH  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [12:0] mbnumber,
    output logic [7:0]  blk_row,
    output logic [7:0]  blk_col,
    output logic        last
);
    import intra_pkg::*;

    localparam int unsigned BPR = blocks_per_row(WIDTH);
    localparam int unsigned BPF = blocks_per_frame(LENGTH, WIDTH);

    logic [5:0] row_idx;
    logic [5:0] col_idx;

    // Row/col tracked as separate indices so no divider is needed
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mbnumber <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            last     <= (BPF == 1);
        end else if (inc && !last) begin
            mbnumber <= mbnumber + 13'd1;
            if (col_idx == 6'(BPR - 1)) begin
                col_idx <= '0;
                row_idx <= row_idx + 6'd1;
            end else begin
                col_idx <= col_idx + 6'd1;
            end
            // Next index is last when the current one is second-to-last
            last <= (mbnumber == 13'(BPF - 2));
        end
    end

    assign blk_row = {row_idx, 2'b00};
    assign blk_col = {col_idx, 2'b00};

endmodule

// File: rtl/intra4x4_scheduler.sv
// Frame sequencer for the 4x4 intra-prediction pipeline.
// Walks the frame in raster order of 4x4 blocks: pulses pred_start, gathers
// per-mode done flags, then pulses save_enable with a stable block number.
// Ports: clk, reset (sync, active-high), start, abort, pred_done[NUM_MODES];
//        pred_start, save_enable, mbnumber, blk_row, blk_col, busy,
//        frame_done, timeout_err.
// Build option: define SCHED_TIMEOUT_EN to add the WAIT watchdog
// (TIMEOUT cycles); otherwise timeout_err is tied low.
module intra4x4_scheduler #(
    parameter int unsigned LENGTH    = 256,
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned NUM_MODES = intra_pkg::NUM_MODES,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_MODES-1:0] pred_done,
    output logic                 pred_start,
    output logic                 save_enable,
    output logic [12:0]          mbnumber,
    output logic [7:0]           blk_row,
    output logic [7:0]           blk_col,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err
);
    import intra_pkg::*;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    state_t                state;
    state_t                state_nxt;
    logic [NUM_MODES-1:0]  mask;
    logic [NUM_MODES-1:0]  mask_nxt;
    logic [NUM_MODES-1:0]  mask_all_c;
    logic                  mask_full_c;
    logic                  wd_expired_c;
    logic                  last;
    logic                  cnt_clear;
    logic                  cnt_inc;
    logic                  pred_start_nxt;
    logic                  save_enable_nxt;
    logic                  frame_done_nxt;
    logic                  busy_nxt;

    // Completion includes bits arriving in the current WAIT cycle
    assign mask_all_c  = mask | pred_done;
    assign mask_full_c = &mask_all_c;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mask        <= '0;
            pred_start  <= 1'b0;
            save_enable <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mask        <= mask_nxt;
            pred_start  <= pred_start_nxt;
            save_enable <= save_enable_nxt;
            frame_done  <= frame_done_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state, mask update and output decode
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                mask_nxt  = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                mask_nxt = mask_all_c;
                if (mask_full_c)       state_nxt = ST_SAVE;
                else if (wd_expired_c) state_nxt = ST_ADVANCE;
            end
            ST_SAVE: begin
                state_nxt = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ISSUE;
                    cnt_inc   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident start
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_inc   = 1'b0;
        end

        cnt_clear       = (state_nxt == ST_IDLE);
        pred_start_nxt  = (state_nxt == ST_ISSUE);
        save_enable_nxt = (state_nxt == ST_SAVE);
        frame_done_nxt  = (state_nxt == ST_DONE);
        busy_nxt        = (state_nxt != ST_IDLE);
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_set_c;

    assign wd_expired_c  = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign timeout_set_c = (state == ST_WAIT) && !mask_full_c && wd_expired_c && !abort;

    // WAIT watchdog; error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE)     wd_cnt <= '0;
            else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (timeout_set_c)         timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expired_c = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    intra_block_counter #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .mbnumber (mbnumber),
        .blk_row  (blk_row),
        .blk_col  (blk_col),
        .last     (last)
    );

endmodule

// File: tb/tb_intra4x4_scheduler.sv
// Self-checking bench for intra4x4_scheduler on an 8x8 frame (4 blocks).
// Randomized done-flag patterns, start hold and abort points are checked
// cycle by cycle against a transaction-level expectation of the frame walk.
module tb_intra4x4_scheduler;
    localparam int unsigned LEN  = 8;
    localparam int unsigned WID  = 8;
    localparam int unsigned NM   = 8;
    localparam int unsigned TO   = 16;
    localparam int unsigned BPR  = WID / 4;
    localparam int unsigned NBLK = (LEN / 4) * (WID / 4);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NM-1:0] pred_done;
    logic          pred_start;
    logic          save_enable;
    logic [12:0]   mbnumber;
    logic [7:0]    blk_row;
    logic [7:0]    blk_col;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    int   total = 0;
    int   bad   = 0;
    logic exp_terr = 1'b0;

    always #5 clk = ~clk;

    intra4x4_scheduler #(
        .LENGTH    (LEN),
        .WIDTH     (WID),
        .NUM_MODES (NM),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pred_done   (pred_done),
        .pred_start  (pred_start),
        .save_enable (save_enable),
        .mbnumber    (mbnumber),
        .blk_row     (blk_row),
        .blk_col     (blk_col),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for one cycle; coordinates come from raster arithmetic
    task automatic expect_out(input string tag, input bit ps, input bit sv, input bit fd,
                              input bit bsy, input int mb);
        chk({tag, ".pred_start"},  32'(pred_start),  32'(ps));
        chk({tag, ".save_enable"}, 32'(save_enable), 32'(sv));
        chk({tag, ".frame_done"},  32'(frame_done),  32'(fd));
        chk({tag, ".busy"},        32'(busy),        32'(bsy));
        chk({tag, ".mbnumber"},    32'(mbnumber),    32'(mb));
        chk({tag, ".blk_row"},     32'(blk_row),     32'(4 * (mb / BPR)));
        chk({tag, ".blk_col"},     32'(blk_col),     32'(4 * (mb % BPR)));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_terr));
    endtask

    // One frame; abort_blk/timeout_blk select a block for abort or a stuck mode (-1 = none)
    task automatic run_frame(input bit hold, input int abort_blk, input int timeout_blk);
        int            n;
        int            ai;
        logic [NM-1:0] hold_bit;
        logic [NM-1:0] acc;
        start     = 1'b1;
        abort     = 1'b0;
        pred_done = NM'($urandom);
        step();
        expect_out("start", 1, 0, 0, 1, 0);
        if (!hold) start = 1'b0;
        for (int b = 0; b < NBLK; b++) begin
            // pred_done during ISSUE must be ignored
            pred_done = NM'($urandom);
            step();
            expect_out("wait0", 0, 0, 0, 1, b);
            if (b == timeout_blk) begin
                for (int k = 0; k < TO; k++) begin
                    pred_done = NM'($urandom) & 8'h7F;
                    step();
                    if (k == TO - 1) exp_terr = 1'b1;
                    expect_out("tmo", 0, 0, 0, 1, b);
                end
            end else begin
                n        = $urandom_range(1, 5);
                ai       = (b == abort_blk) ? $urandom_range(0, n - 1) : -1;
                hold_bit = NM'(1) << $urandom_range(0, NM - 1);
                acc      = '0;
                for (int i = 0; i < n; i++) begin
                    if (i < n - 1) pred_done = NM'($urandom) & ~hold_bit;
                    else           pred_done = ~acc | NM'($urandom);
                    acc = acc | pred_done;
                    if (i == ai) begin
                        abort = 1'b1;
                        start = 1'b0;
                        step();
                        expect_out("abort", 0, 0, 0, 0, 0);
                        abort     = 1'b0;
                        pred_done = '0;
                        step();
                        expect_out("post_abort", 0, 0, 0, 0, 0);
                        return;
                    end
                    step();
                    if (&acc) expect_out("save", 0, 1, 0, 1, b);
                    else      expect_out("waiting", 0, 0, 0, 1, b);
                end
                pred_done = NM'($urandom);
                step();
                expect_out("advance", 0, 0, 0, 1, b);
            end
            pred_done = NM'($urandom);
            step();
            if (b == NBLK - 1) begin
                expect_out("done", 0, 0, 1, 1, b);
                start = 1'b0;
                step();
                expect_out("idle", 0, 0, 0, 0, 0);
            end else begin
                expect_out("issue", 1, 0, 0, 1, b + 1);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        pred_done = '0;
        step();
        step();
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        step();
        expect_out("start_abort", 0, 0, 0, 0, 0);
        start = 1'b0;
        abort = 1'b0;

        // Staggered completion: 0x0F, then 0xF0 three cycles later
        start = 1'b1;
        step();
        expect_out("stg_issue", 1, 0, 0, 1, 0);
        start     = 1'b0;
        pred_done = 8'hFF;
        step();
        expect_out("stg_wait", 0, 0, 0, 1, 0);
        pred_done = 8'h0F;
        step();
        expect_out("stg_0f", 0, 0, 0, 1, 0);
        pred_done = 8'h00;
        step();
        expect_out("stg_gap1", 0, 0, 0, 1, 0);
        step();
        expect_out("stg_gap2", 0, 0, 0, 1, 0);
        pred_done = 8'hF0;
        step();
        expect_out("stg_save", 0, 1, 0, 1, 0);
        pred_done = '0;
        abort     = 1'b1;
        step();
        expect_out("stg_abort", 0, 0, 0, 0, 0);
        abort = 1'b0;

        run_frame(1'b0, -1, -1);
        run_frame(1'b1, -1, -1);
        run_frame(1'b0, 2, -1);
`ifdef SCHED_TIMEOUT_EN
        run_frame(1'b0, -1, 1);
`endif
        for (int f = 0; f < 12; f++) begin
            run_frame(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NBLK - 1)) : -1,
                      -1);
        end

        // Reset during SAVE clears everything
        start = 1'b1;
        step();
        expect_out("rs_issue", 1, 0, 0, 1, 0);
        start     = 1'b0;
        pred_done = '0;
        step();
        pred_done = 8'hFF;
        step();
        expect_out("rs_save", 0, 1, 0, 1, 0);
        reset     = 1'b1;
        pred_done = '0;
        step();
        exp_terr = 1'b0;
        expect_out("rs_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        run_frame(1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog on total simulation time
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
